// File: rtl/b_recv_ctrl.sv
// b_recv_ctrl: B-side toggle-handshake receiver; word valid SYNC_STAGES+1 bclk edges after breq_tgl flips, held until bready.
// Optional sticky protocol-error flag berr is built in when CDC_RECV_ERR_EN is defined.
module b_recv_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             bclk,
  input  logic             brst,
  input  logic             breq_tgl,
  input  logic [WIDTH-1:0] bdata_in,
  output logic             bvalid,
  input  logic             bready,
  output logic [WIDTH-1:0] bdata,
  output logic             back_tgl
`ifdef CDC_RECV_ERR_EN
  ,
  output logic             berr
`endif
);

  typedef enum logic {IDLE, VALID} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_prev, req_prev_nxt;
  logic                   req_edge;
  logic                   bvalid_nxt;
  logic                   back_nxt;
  logic [WIDTH-1:0]       bdata_nxt;

  // req_prev only follows the synchroniser when an edge is consumed, so an edge
  // seen during VALID stays pending until the next IDLE cycle.
  assign req_edge = sync[SYNC_STAGES-1] ^ req_prev;

  always_ff @(posedge bclk or posedge brst) begin
    if (brst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], breq_tgl};
    end
  end

  always_ff @(posedge bclk or posedge brst) begin
    if (brst) begin
      state    <= IDLE;
      req_prev <= 1'b0;
      bvalid   <= 1'b0;
      bdata    <= '0;
      back_tgl <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_prev <= req_prev_nxt;
      bvalid   <= bvalid_nxt;
      bdata    <= bdata_nxt;
      back_tgl <= back_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    req_prev_nxt = req_prev;
    bvalid_nxt   = bvalid;
    bdata_nxt    = bdata;
    back_nxt     = back_tgl;
    case (state)
      IDLE: begin
        if (req_edge) begin
          bdata_nxt    = bdata_in;
          bvalid_nxt   = 1'b1;
          req_prev_nxt = sync[SYNC_STAGES-1];
          state_nxt    = VALID;
        end
      end
      VALID: begin
        if (bvalid && bready) begin
          bvalid_nxt = 1'b0;
          back_nxt   = ~back_tgl;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CDC_RECV_ERR_EN
  // Sender toggled again before it could have seen our acknowledge.
  always_ff @(posedge bclk or posedge brst) begin
    if (brst) begin
      berr <= 1'b0;
    end else if (state == VALID && req_edge) begin
      berr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_b_recv_ctrl.sv
// Directed bench for b_recv_ctrl (WIDTH=8, SYNC_STAGES=2) with a model A-side sender for the stream case.
module tb_b_recv_ctrl;

  logic       bclk;
  logic       brst;
  logic       breq_tgl;
  logic [7:0] bdata_in;
  logic       bvalid;
  logic       bready;
  logic [7:0] bdata;
  logic       back_tgl;
`ifdef CDC_RECV_ERR_EN
  logic       berr;
`endif

  int total = 0;
  int bad   = 0;

  b_recv_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .bclk     (bclk),
    .brst     (brst),
    .breq_tgl (breq_tgl),
    .bdata_in (bdata_in),
    .bvalid   (bvalid),
    .bready   (bready),
    .bdata    (bdata),
    .back_tgl (back_tgl)
`ifdef CDC_RECV_ERR_EN
    ,
    .berr     (berr)
`endif
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       a_tgl, a_s1, a_s2, hs, prev_back;
    logic [7:0] dseen;
    int         sent, rcvd, togs, cyc;

    brst     = 1'b1;
    breq_tgl = 1'b0;
    bdata_in = 8'h00;
    bready   = 1'b0;
    tick();
    tick();
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_bdata", {24'd0, bdata}, 32'h00);
    chk("rst_back", {31'd0, back_tgl}, 32'd0);
    brst = 1'b0;
    tick();

    // Single transfer: valid after edge 3, acknowledged at edge 4.
    bdata_in = 8'hA5;
    breq_tgl = 1'b1;
    bready   = 1'b1;
    tick();
    chk("single_e1_bvalid", {31'd0, bvalid}, 32'd0);
    tick();
    chk("single_e2_bvalid", {31'd0, bvalid}, 32'd0);
    tick();
    chk("single_e3_bvalid", {31'd0, bvalid}, 32'd1);
    chk("single_e3_bdata", {24'd0, bdata}, 32'hA5);
    tick();
    chk("single_e4_bvalid", {31'd0, bvalid}, 32'd0);
    chk("single_e4_back", {31'd0, back_tgl}, 32'd1);
    chk("single_e4_bdata_hold", {24'd0, bdata}, 32'hA5);
    tick();
    tick();

    // Consumer stall for 5 cycles.
    bready   = 1'b0;
    bdata_in = 8'h3C;
    breq_tgl = 1'b0;
    tick();
    tick();
    tick();
    chk("stall_cap_bvalid", {31'd0, bvalid}, 32'd1);
    chk("stall_cap_bdata", {24'd0, bdata}, 32'h3C);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_bvalid", {31'd0, bvalid}, 32'd1);
      chk("stall_bdata", {24'd0, bdata}, 32'h3C);
      chk("stall_back", {31'd0, back_tgl}, 32'd1);
    end
    bready = 1'b1;
    tick();
    chk("stall_rel_bvalid", {31'd0, bvalid}, 32'd0);
    chk("stall_rel_back", {31'd0, back_tgl}, 32'd0);
    tick();
    tick();

    // Pending edge: second toggle arrives while the first word is unconsumed.
    bready   = 1'b0;
    bdata_in = 8'h11;
    breq_tgl = 1'b1;
    tick();
    tick();
    tick();
    chk("pend_first_bvalid", {31'd0, bvalid}, 32'd1);
    chk("pend_first_bdata", {24'd0, bdata}, 32'h11);
    bdata_in = 8'h22;
    breq_tgl = 1'b0;
    tick();
    tick();
    tick();
    chk("pend_hold_bvalid", {31'd0, bvalid}, 32'd1);
    chk("pend_hold_bdata", {24'd0, bdata}, 32'h11);
`ifdef CDC_RECV_ERR_EN
    chk("pend_berr", {31'd0, berr}, 32'd1);
`endif
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("pend_gap_bvalid", {31'd0, bvalid}, 32'd0);
    chk("pend_gap_back", {31'd0, back_tgl}, 32'd1);
    tick();
    chk("pend_second_bvalid", {31'd0, bvalid}, 32'd1);
    chk("pend_second_bdata", {24'd0, bdata}, 32'h22);
    bready = 1'b1;
    tick();
    chk("pend_second_ack_bvalid", {31'd0, bvalid}, 32'd0);
    chk("pend_second_ack_back", {31'd0, back_tgl}, 32'd0);
`ifdef CDC_RECV_ERR_EN
    chk("pend_berr_sticky", {31'd0, berr}, 32'd1);
`endif
    tick();

    // Reset mid-transfer; sender resets too, so breq_tgl returns to 0.
    bdata_in = 8'h77;
    breq_tgl = 1'b1;
    tick();
    #2;
    brst     = 1'b1;
    breq_tgl = 1'b0;
    #1;
    chk("arst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("arst_bdata", {24'd0, bdata}, 32'h00);
    chk("arst_back", {31'd0, back_tgl}, 32'd0);
`ifdef CDC_RECV_ERR_EN
    chk("arst_berr", {31'd0, berr}, 32'd0);
`endif
    tick();
    tick();
    brst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_pulse", {31'd0, bvalid}, 32'd0);
    end
    bdata_in = 8'h5A;
    breq_tgl = 1'b1;
    bready   = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_bvalid", {31'd0, bvalid}, 32'd1);
    chk("post_rst_bdata", {24'd0, bdata}, 32'h5A);
    tick();
    chk("post_rst_ack_bvalid", {31'd0, bvalid}, 32'd0);
    chk("post_rst_back", {31'd0, back_tgl}, 32'd1);
    tick();

    // Stream of 16 words from a model sender that waits for a synchronised ack.
    a_tgl = breq_tgl;
    a_s1  = back_tgl;
    a_s2  = back_tgl;
    sent  = 0;
    rcvd  = 0;
    togs  = 0;
    cyc   = 0;
    while ((rcvd < 16 || cyc < 200) && cyc < 3000) begin
      a_s2 = a_s1;
      a_s1 = back_tgl;
      if (a_s2 == a_tgl && sent < 16) begin
        bdata_in = 8'(sent);
        a_tgl    = ~a_tgl;
        breq_tgl = a_tgl;
        sent++;
      end
      bready    = 1'($urandom_range(0, 1));
      hs        = bvalid && bready;
      dseen     = bdata;
      prev_back = back_tgl;
      tick();
      cyc++;
      if (hs) begin
        chk("stream_word", {24'd0, dseen}, 32'(rcvd));
        rcvd++;
      end
      if (back_tgl != prev_back) togs++;
    end
    chk("stream_count", 32'(rcvd), 32'd16);
    chk("stream_back_toggles", 32'(togs), 32'd16);
    chk("stream_idle_bvalid", {31'd0, bvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
